// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word 1101, then a DATA_W-bit payload sent MSB first.
// A zero is stuffed after every 110 inside the payload, and each frame ends with a GAP-cycle idle tail.
module sync_frame_tx #(
   parameter int DATA_W = 8,
   parameter int GAP    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_start,
   input  logic [DATA_W-1:0]           tx_data,
   output logic                        o,
   output logic                        busy,
   output logic                        tx_done,
   output logic [$clog2(DATA_W+1)-1:0] stuff_cnt
);

   localparam int CW = $clog2(DATA_W+1);
   localparam int GW = $clog2(GAP+1);
   localparam logic [3:0] SYNC_W = 4'b1101;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_GAP} state_t;

   // r_state names the phase of the bit currently shown on o
   state_t            r_state, w_state;
   logic [1:0]        r_idx,   w_idx;
   logic [CW-1:0]     r_rem,   w_rem;
   logic [DATA_W-1:0] r_shift, w_shift;
   logic [2:0]        r_hist,  w_hist;
   logic [GW-1:0]     r_gap,   w_gap;
   logic [CW-1:0]     r_stuff, w_stuff;
   logic              r_o, w_o;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              w_take;

   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_rem   = r_rem;
      w_shift = r_shift;
      w_hist  = r_hist;
      w_gap   = r_gap;
      w_stuff = r_stuff;
      w_busy  = r_busy;
      w_o     = 1'b0;
      w_done  = 1'b0;
      w_take  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (tx_start) begin
               w_state = S_SYNC;
               w_idx   = 2'd0;
               w_o     = SYNC_W[3];
               w_hist  = {2'b00, SYNC_W[3]};
               w_shift = tx_data;
               w_rem   = CW'(DATA_W);
               w_stuff = '0;
               w_busy  = 1'b1;
            end
         end
         S_SYNC: begin
            if (r_idx == 2'd3) begin
               w_take = 1'b1;
            end else begin
               w_idx  = r_idx + 2'd1;
               w_o    = SYNC_W[2'd2 - r_idx];
               w_hist = {r_hist[1:0], SYNC_W[2'd2 - r_idx]};
            end
         end
         S_DATA: begin
            if (r_rem == '0) begin
               w_state = S_GAP;
               w_gap   = GW'(1);
               w_done  = 1'b1;
            end else if (r_hist == 3'b110) begin
               // a 1 here would complete 1101, so force a zero first
               w_state = S_STUFF;
               w_hist  = {r_hist[1:0], 1'b0};
               w_stuff = r_stuff + CW'(1);
            end else begin
               w_take = 1'b1;
            end
         end
         S_STUFF: w_take = 1'b1;
         S_GAP: begin
            if (r_gap == GW'(GAP)) begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
            end else begin
               w_gap = r_gap + GW'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      endcase
      if (w_take) begin
         w_state = S_DATA;
         w_o     = r_shift[DATA_W-1];
         w_shift = r_shift << 1;
         w_rem   = r_rem - CW'(1);
         w_hist  = {r_hist[1:0], r_shift[DATA_W-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_rem   <= '0;
         r_shift <= '0;
         r_hist  <= '0;
         r_gap   <= '0;
         r_stuff <= '0;
         r_o     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_rem   <= w_rem;
         r_shift <= w_shift;
         r_hist  <= w_hist;
         r_gap   <= w_gap;
         r_stuff <= w_stuff;
         r_o     <= w_o;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign o         = r_o;
   assign busy      = r_busy;
   assign tx_done   = r_done;
   assign stuff_cnt = r_stuff;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: a list-based frame model feeds an expected queue, and a
// monitor checks each frame, its gap, idle behaviour and a 1101 detector on the line.
module tb_sync_frame_tx;
   localparam int DW = 8;
   localparam int GP = 2;
   localparam int CW = $clog2(DW+1);

   logic          clk = 1'b0;
   logic          rst, tx_start;
   logic [DW-1:0] tx_data;
   logic          o, busy, tx_done;
   logic [CW-1:0] stuff_cnt;

   sync_frame_tx #(.DATA_W(DW), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .o(o), .busy(busy), .tx_done(tx_done), .stuff_cnt(stuff_cnt)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_seen = 1'b0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   typedef struct {
      logic [31:0] bits;
      int          len;
      int          stuff;
      int          t0;
   } frame_t;

   frame_t exp_q[$];
   int tests = 0, fails = 0;
   int idle_bad = 0, bad_hits = 0, n_sent = 0, n_done = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Frame as a bit list: sync, then payload MSB first; a 0 follows any 110 while payload remains.
   function automatic frame_t model(input logic [DW-1:0] d, input int t0);
      frame_t     f;
      logic [3:0] s;
      s = 4'b1101;
      f.bits = '0; f.len = 0; f.stuff = 0; f.t0 = t0;
      for (int i = 3; i >= 0; i--) begin
         f.bits = {f.bits[30:0], s[i]}; f.len++;
      end
      for (int i = DW-1; i >= 0; i--) begin
         f.bits = {f.bits[30:0], d[i]}; f.len++;
         if (i > 0 && f.bits[2:0] == 3'b110) begin
            f.bits = {f.bits[30:0], 1'b0}; f.len++; f.stuff++;
         end
      end
      return f;
   endfunction

   // Monitor: phase 0 idle, 1 frame bits, 2 gap
   initial begin
      int          phase, pos, gapn, hits, last_stuff;
      logic [31:0] cap;
      logic [3:0]  det;
      frame_t      cur;
      phase = 0; pos = 0; gapn = 0; hits = 0; last_stuff = 0; cap = '0; det = '0;
      cur = '{bits: '0, len: 0, stuff: 0, t0: 0};
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            det = {det[2:0], o};
            if (rst_seen) begin
               check("reset_state", {o, busy, tx_done, stuff_cnt}, '0);
               exp_q.delete();
               phase = 0; last_stuff = 0;
            end else begin
               if (det == 4'b1101) begin
                  if (phase == 1 && pos == 3) hits++;
                  else bad_hits++;
               end
               case (phase)
                  0: begin
                     if (busy) begin
                        if (exp_q.size() == 0) begin
                           check("unexpected_frame", 1, 0);
                           cur = '{bits: '0, len: 0, stuff: 0, t0: cyc - 1};
                        end else begin
                           cur = exp_q.pop_front();
                        end
                        check("start_latency", cyc, cur.t0 + 1);
                        cap = {31'b0, o}; pos = 1; hits = 0; phase = 1;
                     end else if (o !== 1'b0 || tx_done !== 1'b0 || stuff_cnt !== CW'(last_stuff)) begin
                        idle_bad++;
                     end
                  end
                  1: begin
                     if (busy !== 1'b1) idle_bad++;
                     if (tx_done) begin
                        check("frame_len", pos, cur.len);
                        check("frame_bits", cap, cur.bits);
                        check("stuff_cnt", stuff_cnt, cur.stuff);
                        check("sync_hits", hits, 1);
                        if (o !== 1'b0) idle_bad++;
                        last_stuff = cur.stuff; gapn = 1; phase = 2; n_done++;
                     end else begin
                        cap = {cap[30:0], o}; pos++;
                        if (pos > 40) begin
                           check("frame_timeout", pos, cur.len);
                           phase = 0;
                        end
                     end
                  end
                  default: begin
                     if (busy) begin
                        gapn++;
                        if (o !== 1'b0 || tx_done !== 1'b0) idle_bad++;
                     end else begin
                        check("gap_len", gapn, GP);
                        if (o !== 1'b0 || stuff_cnt !== CW'(last_stuff)) idle_bad++;
                        phase = 0;
                     end
                  end
               endcase
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n <= 100) begin
         @(negedge clk);
         n++;
      end
      if (n > 100) check("idle_timeout", n, 0);
   endtask

   // Returns after the accepting edge; t0 is the cycle count before that edge
   task automatic start(input logic [DW-1:0] d, output int t0);
      @(negedge clk);
      wait_idle();
      tx_data  = d;
      tx_start = 1'b1;
      t0       = cyc;
      exp_q.push_back(model(d, cyc));
      @(posedge clk);
      #1 tx_start = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d);
      int t0;
      start(d, t0);
      n_sent++;
   endtask

   initial begin
      int          t0;
      logic [DW-1:0] d;
      rst = 1'b1; tx_start = 1'b1; tx_data = 8'hA5;
      repeat (3) @(negedge clk);
      rst = 1'b0; tx_start = 1'b0;
      repeat (5) @(negedge clk);
      check("post_reset_busy", busy, 0);

      send(8'h00); send(8'hB0); send(8'hFF); send(8'hDB);
      for (int i = 0; i < 256; i++) send(DW'(i));
      repeat (200) send(DW'($urandom));
      @(negedge clk); wait_idle();

      // start pulses and data changes mid-frame must not affect or queue anything
      d = DW'($urandom);
      start(d, t0);
      n_sent++;
      while (cyc - t0 < 20) begin
         @(negedge clk);
         tx_start = (cyc - t0 == 3) || (cyc - t0 == 7) || (cyc - t0 == 13);
         if (cyc - t0 == 6) tx_data = ~d;
      end
      tx_start = 1'b0;
      repeat (5) @(negedge clk);
      check("no_queued_frame", {busy, 32'(exp_q.size())}, '0);

      // reset in the middle of a frame abandons it; a fresh frame follows cleanly
      start(8'hDB, t0);
      while (cyc - t0 < 8) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      send(8'hB0);

      @(negedge clk); wait_idle();
      repeat (5) @(negedge clk);
      check("pending_expected", exp_q.size(), 0);
      check("frames_done", n_done, n_sent);
      check("idle_violations", idle_bad, 0);
      check("stray_sync_hits", bad_hits, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
